// File: rtl/shift_pkg.sv
// Shared definitions for the shifter command sequencer.
// Contents:
//   - Op codes. These match the select encoding of the external shifter.
//   - The sequencer FSM state encoding.
package shift_pkg;

    localparam logic [2:0] OP_CLR = 3'b000;  // clear
    localparam logic [2:0] OP_LD  = 3'b001;  // load inp
    localparam logic [2:0] OP_LSR = 3'b010;  // logic right
    localparam logic [2:0] OP_LSL = 3'b011;  // logic left
    localparam logic [2:0] OP_ASR = 3'b100;  // arith right
    localparam logic [2:0] OP_ASL = 3'b101;  // arith left: keep msb, [1:0] up, lsb 0
    localparam logic [2:0] OP_ROR = 3'b110;  // rotate right
    localparam logic [2:0] OP_ROL = 3'b111;  // rotate left

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StCapture,
        StResp
    } state_e;

endpackage

// File: rtl/shift_sequencer.sv
// Command-driven controller for the external multi-mode shifter.
// It accepts one command (op, load value, shift count) over a valid/ready
// handshake. It then drives the shifter with one load cycle followed by N
// shift cycles. It captures the registered shifter output and returns it on
// a valid/ready response channel.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_op, cmd_data, cmd_cnt       command fields
//   abort                           synchronous cancel, wins over everything
//   shf_sel, shf_inp                to shifter (decoded from registered state only)
//   shf_q                           from shifter output register
//   rsp_valid/rsp_ready, rsp_data   response channel
//   busy                            FSM not idle
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic             abort,
    output logic [2:0]       shf_sel,
    output logic [WIDTH-1:0] shf_inp,
    input  logic [WIDTH-1:0] shf_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            cnt_q       <= cnt_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        cnt_d       = cnt_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;
        cmd_ready   = 1'b0;
        // Outside LOAD/SHIFT the shifter reloads the last result so it never free-runs.
        shf_sel     = OP_LD;
        shf_inp     = rsp_data_q;

        unique case (state_q)
            StIdle: begin
                cmd_ready = !abort;
                if (cmd_valid && !abort) begin
                    op_d    = cmd_op;
                    data_d  = cmd_data;
                    cnt_d   = cmd_cnt;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shf_inp = data_q;
                if (op_q >= OP_LSR) begin
                    shf_sel = OP_LD;
                    state_d = (cnt_q == '0) ? StCapture : StShift;
                end else begin
                    // Clear/load finish in this one cycle; the count is ignored.
                    shf_sel = op_q;
                    state_d = StCapture;
                end
            end
            StShift: begin
                shf_sel = op_q;
                shf_inp = data_q;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                rsp_data_d  = shf_q;
                rsp_valid_d = 1'b1;
                state_d     = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort drops whatever is in flight and leaves the previous result in place.
        if (abort) begin
            state_d     = StIdle;
            rsp_valid_d = 1'b0;
            rsp_data_d  = rsp_data_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural 4-bit shifter
// closing the loop on shf_sel/shf_inp -> shf_q.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [2:0] cmd_cnt;
    logic       abort;
    logic [2:0] shf_sel;
    logic [3:0] shf_inp;
    logic [3:0] shf_q;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_data;
    logic       busy;

    shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_cnt   (cmd_cnt),
        .abort     (abort),
        .shf_sel   (shf_sel),
        .shf_inp   (shf_inp),
        .shf_q     (shf_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // External shifter model (registered output).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) shf_q <= 4'b0000;
        else begin
            case (shf_sel)
                3'b000: shf_q <= 4'b0000;
                3'b001: shf_q <= shf_inp;
                3'b010: shf_q <= {1'b0, shf_q[3:1]};
                3'b011: shf_q <= {shf_q[2:0], 1'b0};
                3'b100: shf_q <= {shf_q[3], shf_q[3:1]};
                3'b101: shf_q <= {shf_q[3], shf_q[1:0], 1'b0};
                3'b110: shf_q <= {shf_q[0], shf_q[3:1]};
                default: shf_q <= {shf_q[2:0], shf_q[3]};
            endcase
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [3:0] data;
        int         acc;
        int         lat;
    } exp_t;
    exp_t sb[$];

    int last_hs = 0;
    bit seen    = 1'b0;

    // Monitor: checks each presented response against the oldest expectation.
    always @(negedge clk) begin
        if (!rst_n) seen = 1'b0;
        else if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_rsp: got rsp_data=%0h expected no response", rsp_data);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                end
                chk("rsp_data", 32'(rsp_data), 32'(sb[0].data));
                if (rsp_ready) begin
                    last_hs = cyc + 1;
                    void'(sb.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [2:0] op, input logic [3:0] data, input logic [2:0] cnt,
                        input logic [3:0] exp, input int lat, input bit push, input bit keep,
                        output int acc);
        bit ok = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_cnt   = cnt;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("cmd_accept_timeout", 32'(ok), 32'd1);
        acc = -1;
        if (ok) begin
            @(posedge clk);
            #1;
            acc = cyc;
            if (push) sb.push_back('{data: exp, acc: acc, lat: lat});
        end
        if (!keep || !ok) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (!busy && !rsp_valid && sb.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk("idle_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] data;
        logic [2:0] cnt;
        logic [3:0] exp;
        int         lat;
    } vec_t;

    vec_t vecs [5] = '{
        '{op: 3'b100, data: 4'b1000, cnt: 3'd3, exp: 4'b1111, lat: 5},
        '{op: 3'b111, data: 4'b1001, cnt: 3'd1, exp: 4'b0011, lat: 3},
        '{op: 3'b101, data: 4'b1011, cnt: 3'd1, exp: 4'b1110, lat: 3},
        '{op: 3'b000, data: 4'b1111, cnt: 3'd5, exp: 4'b0000, lat: 2},
        '{op: 3'b011, data: 4'b0110, cnt: 3'd0, exp: 4'b0110, lat: 2}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_a;
        int acc_b;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'b000;
        cmd_data  = 4'b0000;
        cmd_cnt   = 3'd0;
        abort     = 1'b0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state.
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_shf_sel", 32'(shf_sel), 32'b001);
        chk("rst_shf_inp", 32'(shf_inp), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(posedge clk);
        #1;

        // LSR 1011 by 2: select sequence 001,010,010 then back to 001.
        send(3'b010, 4'b1011, 3'd2, 4'b0010, 4, 1'b1, 1'b0, acc_a);
        @(negedge clk);
        chk("t1_sel_load", 32'(shf_sel), 32'b001);
        chk("t1_inp_load", 32'(shf_inp), 32'b1011);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("t1_sel_shift1", 32'(shf_sel), 32'b010);
        @(negedge clk);
        chk("t1_sel_shift2", 32'(shf_sel), 32'b010);
        @(negedge clk);
        chk("t1_sel_capture", 32'(shf_sel), 32'b001);
        wait_idle();

        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].data, vecs[i].cnt, vecs[i].exp, vecs[i].lat,
                 1'b1, 1'b0, acc_a);
            wait_idle();
        end

        // Back-pressure: response held 5 cycles while the next command waits.
        rsp_ready = 1'b0;
        fork
            begin
                send(3'b110, 4'b0110, 3'd2, 4'b1001, 4, 1'b1, 1'b1, acc_a);
                send(3'b001, 4'b0101, 3'd0, 4'b0101, 2, 1'b1, 1'b0, acc_b);
            end
            begin
                bit got = 1'b0;
                for (int n = 0; n < 60; n++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("hold_rsp_timeout", 32'(got), 32'd1);
                for (int i = 0; i < 5; i++) begin
                    chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
                    chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
                    if (i < 4) @(negedge clk);
                end
                @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        chk("accept_after_hs", 32'(acc_b), 32'(last_hs + 1));
        wait_idle();

        // Abort in the second SHIFT cycle of a count-6 command.
        send(3'b011, 4'b0001, 3'd6, 4'b0000, 0, 1'b0, 1'b0, acc_a);
        @(posedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_data", 32'(rsp_data), 32'b0101);
        repeat (8) @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;

        // Abort with cmd_valid in IDLE blocks acceptance.
        cmd_valid = 1'b1;
        cmd_op    = 3'b001;
        cmd_data  = 4'b1010;
        cmd_cnt   = 3'd0;
        abort     = 1'b1;
        @(negedge clk);
        chk("idle_abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        @(negedge clk);
        chk("idle_abort_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SHIFT.
        send(3'b010, 4'b1111, 3'd6, 4'b0000, 0, 1'b0, 1'b0, acc_a);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("mid_rst_shf_sel", 32'(shf_sel), 32'b001);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(3'b110, 4'b0001, 3'd1, 4'b1000, 3, 1'b1, 1'b0, acc_a);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
